// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: MSB-first serial pattern transmitter with hold gap and detector z model.
// Define PATTERN_LOOP_EN to let `loop` repeat the latched pattern without a gap.
module serial_pattern_gen #(
   parameter int PW      = 8,
   parameter int CW      = 5,
   parameter int GAP_CYC = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [PW-1:0] pattern,
   input  logic [CW-1:0] len,
   input  logic          loop,
   output logic          w,
   output logic          busy,
   output logic          done,
   output logic          z_exp
);
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
   state_t        state, state_n;
   logic [PW-1:0] sh, sh_n;
   logic [CW-1:0] cnt, cnt_n, eff_len;
   logic          w_n, done_n, last_w, seen;
`ifdef PATTERN_LOOP_EN
   logic [PW-1:0] pat_q;
   logic [CW-1:0] len_q;
`else
   logic          unused_loop;
   assign unused_loop = loop;
`endif
   assign eff_len = (len == '0 || int'(len) > PW) ? CW'(PW) : len;
   assign busy    = state != IDLE;
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      w_n     = w;
      done_n  = 1'b0;
      case (state)
         IDLE:
            if (start) begin
               state_n = SEND;
               sh_n    = pattern;
               w_n     = pattern[PW-1];
               cnt_n   = eff_len - CW'(1);
            end
         SEND:
            if (cnt != '0) begin
               sh_n  = sh << 1;
               w_n   = sh[PW-2];
               cnt_n = cnt - CW'(1);
            end
`ifdef PATTERN_LOOP_EN
            else if (loop) begin
               sh_n  = pat_q;
               w_n   = pat_q[PW-1];
               cnt_n = len_q - CW'(1);
            end
`endif
            else if (GAP_CYC > 0) begin
               state_n = GAP;
               cnt_n   = CW'(GAP_CYC - 1);
            end else begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         GAP:
            if (cnt != '0) cnt_n = cnt - CW'(1);
            else begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         default: state_n = IDLE;
      endcase
   end
   // z_exp samples w every edge in every state, like the detector's own flops
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state  <= IDLE;
         sh     <= '0;
         cnt    <= '0;
         w      <= 1'b0;
         done   <= 1'b0;
         z_exp  <= 1'b0;
         last_w <= 1'b0;
         seen   <= 1'b0;
`ifdef PATTERN_LOOP_EN
         pat_q  <= '0;
         len_q  <= '0;
`endif
      end else begin
         state  <= state_n;
         sh     <= sh_n;
         cnt    <= cnt_n;
         w      <= w_n;
         done   <= done_n;
         z_exp  <= seen & (w == last_w);
         last_w <= w;
         seen   <= 1'b1;
`ifdef PATTERN_LOOP_EN
         if (state == IDLE && start) begin
            pat_q <= pattern;
            len_q <= eff_len;
         end
`endif
      end
endmodule
